exu_lsagu_ctrl: RTL

Load/store requestor on the AGU port of the shared ALU datapath in the EXU. Accepts one memory instruction at a time and computes its effective address (rs1 + imm) through the datapath's AGU add path. It then runs one ICB-style command/response transaction to memory and returns aligned, extended load data or a store completion to writeback. Multi-cycle FSM with valid/ready handshakes on the dispatch, bus and writeback sides.

---
 rtl/exu_lsagu_ctrl_pkg.sv | 27 ++
 rtl/exu_lsagu_align.sv | 41 ++++
 rtl/exu_lsagu_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/exu_lsagu_ctrl_pkg.sv
// Shared encodings for the EXU load/store AGU requestor.
package exu_lsagu_ctrl_pkg;

  typedef enum logic [1:0] {
    AGU_ST_IDLE = 2'd0,
    AGU_ST_CMD  = 2'd1,
    AGU_ST_RSP  = 2'd2,
    AGU_ST_WB   = 2'd3
  } agu_state_e;

  localparam logic [1:0] AGU_SZ_B = 2'b00;
  localparam logic [1:0] AGU_SZ_H = 2'b01;
  localparam logic [1:0] AGU_SZ_W = 2'b10;

  // Natural-alignment test; the reserved size code is always treated as misaligned.
  function automatic logic agu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      AGU_SZ_B: mis = 1'b0;
      AGU_SZ_H: mis = addr_lo[0];
      AGU_SZ_W: mis = (addr_lo != 2'b00);
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exu_lsagu_align.sv
// Byte-lane steering: store data replication and byte mask, load shift and extension.
// The reserved size code falls through to word handling.
module exu_lsagu_align
  import exu_lsagu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic            usign,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wmask,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  // Lane selection per access size; mask bits shifted past lane 3 are dropped.
  always_comb begin
    ld_shifted = ld_rdata >> {addr_lo, 3'b000};
    st_wdata   = st_data;
    st_wmask   = 4'b1111;
    ld_data    = ld_shifted;
    case (size)
      AGU_SZ_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wmask = 4'b0001 << addr_lo;
        ld_data  = {{24{~usign & ld_shifted[7]}}, ld_shifted[7:0]};
      end
      AGU_SZ_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wmask = 4'b0011 << addr_lo;
        ld_data  = {{16{~usign & ld_shifted[15]}}, ld_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exu_lsagu_ctrl.sv
// Load/store requestor on the AGU port of the shared ALU datapath.
// Optional build macro AGU_MISALIGN_CHK_EN: when defined, misaligned accesses
// fault without issuing a bus command; otherwise the raw address is always used.
//
// state | meaning
// IDLE  | ready for a new instruction from dispatch
// CMD   | datapath computes rs1+imm; bus command offered (or misalign fault)
// RSP   | waiting for the bus response
// WB    | result offered to writeback
module exu_lsagu_ctrl
  import exu_lsagu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            agu_i_valid,
  output logic            agu_i_ready,
  input  logic            agu_i_load,
  input  logic            agu_i_store,
  input  logic [1:0]      agu_i_size,
  input  logic            agu_i_usign,
  input  logic [XLEN-1:0] agu_i_rs1,
  input  logic [XLEN-1:0] agu_i_imm,
  input  logic [XLEN-1:0] agu_i_rs2,
  input  logic [4:0]      agu_i_rdidx,
  output logic            agu_busy,
  output logic            agu_req_alu,
  output logic            agu_req_alu_add,
  output logic [XLEN-1:0] agu_req_alu_op1,
  output logic [XLEN-1:0] agu_req_alu_op2,
  input  logic [XLEN-1:0] agu_req_alu_res,
  output logic            agu_icb_cmd_valid,
  input  logic            agu_icb_cmd_ready,
  output logic [XLEN-1:0] agu_icb_cmd_addr,
  output logic            agu_icb_cmd_read,
  output logic [XLEN-1:0] agu_icb_cmd_wdata,
  output logic [3:0]      agu_icb_cmd_wmask,
  input  logic            agu_icb_rsp_valid,
  output logic            agu_icb_rsp_ready,
  input  logic [XLEN-1:0] agu_icb_rsp_rdata,
  input  logic            agu_icb_rsp_err,
  output logic            agu_o_valid,
  input  logic            agu_o_ready,
  output logic [XLEN-1:0] agu_o_wdat,
  output logic [4:0]      agu_o_rdidx,
  output logic            agu_o_wen,
  output logic            agu_o_err
);

  agu_state_e      state_q, state_d;
  logic            load_q, load_d, store_q, store_d, usign_q, usign_d, err_q, err_d;
  logic [1:0]      size_q, size_d, addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] rs1_q, rs1_d, imm_q, imm_d, rs2_q, rs2_d, rdata_q, rdata_d;
  logic [4:0]      rdidx_q, rdidx_d;

  logic            misalign, in_cmd, in_wb, wb_ok;
  logic [1:0]      align_lo;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_wmask;

`ifdef AGU_MISALIGN_CHK_EN
  assign misalign = agu_misaligned(size_q, agu_req_alu_res[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign in_cmd = (state_q == AGU_ST_CMD);
  assign in_wb  = (state_q == AGU_ST_WB);
  assign wb_ok  = in_wb & load_q & ~err_q;

  // The live sum steers store lanes in CMD; the captured offset steers load lanes in WB.
  assign align_lo = in_cmd ? agu_req_alu_res[1:0] : addr_lo_q;

  exu_lsagu_align #(.XLEN(XLEN)) u_align (
    .size     (size_q),
    .addr_lo  (align_lo),
    .usign    (usign_q),
    .st_data  (rs2_q),
    .ld_rdata (rdata_q),
    .st_wdata (st_wdata),
    .st_wmask (st_wmask),
    .ld_data  (ld_data)
  );

  assign agu_busy          = (state_q != AGU_ST_IDLE);
  assign agu_req_alu_op1   = rs1_q;
  assign agu_req_alu_op2   = imm_q;
  assign agu_icb_cmd_addr  = in_cmd ? agu_req_alu_res : '0;
  assign agu_icb_cmd_read  = in_cmd & ~store_q;
  assign agu_icb_cmd_wdata = in_cmd ? st_wdata : '0;
  assign agu_icb_cmd_wmask = in_cmd ? st_wmask : 4'b0000;
  assign agu_o_wdat        = wb_ok ? ld_data : '0;
  assign agu_o_rdidx       = rdidx_q;
  assign agu_o_wen         = wb_ok;
  assign agu_o_err         = in_wb & err_q;

  // Next-state, handshake outputs and instruction latches.
  always_comb begin
    state_d           = state_q;
    load_d            = load_q;
    store_d           = store_q;
    usign_d           = usign_q;
    err_d             = err_q;
    size_d            = size_q;
    addr_lo_d         = addr_lo_q;
    rs1_d             = rs1_q;
    imm_d             = imm_q;
    rs2_d             = rs2_q;
    rdata_d           = rdata_q;
    rdidx_d           = rdidx_q;
    agu_i_ready       = 1'b0;
    agu_req_alu       = 1'b0;
    agu_req_alu_add   = 1'b0;
    agu_icb_cmd_valid = 1'b0;
    agu_icb_rsp_ready = 1'b0;
    agu_o_valid       = 1'b0;
    case (state_q)
      AGU_ST_IDLE: begin
        agu_i_ready = 1'b1;
        if (agu_i_valid) begin
          load_d  = agu_i_load;
          store_d = agu_i_store;
          usign_d = agu_i_usign;
          size_d  = agu_i_size;
          rs1_d   = agu_i_rs1;
          imm_d   = agu_i_imm;
          rs2_d   = agu_i_rs2;
          rdidx_d = agu_i_rdidx;
          err_d   = 1'b0;
          state_d = AGU_ST_CMD;
        end
      end
      AGU_ST_CMD: begin
        agu_req_alu     = 1'b1;
        agu_req_alu_add = 1'b1;
        if (misalign) begin
          err_d   = 1'b1;
          state_d = AGU_ST_WB;
        end else begin
          agu_icb_cmd_valid = 1'b1;
          if (agu_icb_cmd_ready) begin
            addr_lo_d = agu_req_alu_res[1:0];
            state_d   = AGU_ST_RSP;
          end
        end
      end
      AGU_ST_RSP: begin
        agu_icb_rsp_ready = 1'b1;
        if (agu_icb_rsp_valid) begin
          rdata_d = agu_icb_rsp_rdata;
          err_d   = agu_icb_rsp_err;
          state_d = AGU_ST_WB;
        end
      end
      AGU_ST_WB: begin
        agu_o_valid = 1'b1;
        if (agu_o_ready) state_d = AGU_ST_IDLE;
      end
      default: state_d = AGU_ST_IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= AGU_ST_IDLE;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      usign_q   <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_lo_q <= 2'b00;
      rs1_q     <= '0;
      imm_q     <= '0;
      rs2_q     <= '0;
      rdata_q   <= '0;
      rdidx_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      store_q   <= store_d;
      usign_q   <= usign_d;
      err_q     <= err_d;
      size_q    <= size_d;
      addr_lo_q <= addr_lo_d;
      rs1_q     <= rs1_d;
      imm_q     <= imm_d;
      rs2_q     <= rs2_d;
      rdata_q   <= rdata_d;
      rdidx_q   <= rdidx_d;
    end
  end

endmodule
